// File: rtl/generic_synchronous_packet_fifo_pkg.sv
// Shared types and sizing helpers for the generic synchronous packet FIFO.
package fifo_package;

  typedef enum logic [1:0] {
    WRITE_IDLE,
    WRITE_PACKET,
    WRITE_DISCARD
  } write_state_t;

  // One extra bit beyond the address width carries the wrap flag.
  function automatic int unsigned pointer_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/generic_synchronous_packet_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read with resettable output.
module generic_dual_port_ram #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                     write_clock,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_clock,
  input  logic                     read_reset,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]         read_data
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [WIDTH-1:0] memory [DEPTH];

  always_ff @(posedge write_clock) begin
    if (write_enable) memory[write_address] <= write_data;
  end

  always_ff @(posedge read_clock or posedge read_reset) begin
    if (read_reset)       read_data <= '0;
    else if (read_enable) read_data <= memory[read_address];
  end

endmodule

// File: rtl/generic_synchronous_packet_fifo.sv
// Single-clock FIFO with optional store-and-forward packet mode and first-word-fall-through output.
module generic_synchronous_packet_fifo
  import fifo_package::*;
#(
  parameter int unsigned DATA_WIDTH              = 16,
  parameter int unsigned DATA_DEPTH              = 4096,
  parameter int unsigned FIRST_WORD_FALL_THROUGH = 0,
  parameter int unsigned PACKET_MODE             = 0,
  parameter int unsigned ALMOST_FULL_THRESHOLD   = DATA_DEPTH - 4,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD  = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   write_enable,
  input  logic [DATA_WIDTH-1:0]                  write_data,
  input  logic                                   write_last,
  input  logic                                   write_drop,
  input  logic                                   read_enable,
  output logic [DATA_WIDTH-1:0]                  read_data,
  output logic                                   read_last,
  output logic                                   read_data_valid,
  output logic                                   full,
  output logic                                   empty,
  output logic                                   almost_full,
  output logic                                   almost_empty,
  output logic [pointer_width(DATA_DEPTH)-1:0]   fill_count,
  output logic                                   overflow,
  output logic                                   underflow,
  output logic                                   packet_dropped
);

  localparam int unsigned PW = pointer_width(DATA_DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] ONE        = PW'(1);
  localparam logic [PW-1:0] WRAP_ONLY  = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] FULL_MARK  = PW'(ALMOST_FULL_THRESHOLD);
  localparam logic [PW-1:0] EMPTY_MARK = PW'(ALMOST_EMPTY_THRESHOLD);

  logic [PW-1:0] write_pointer, write_pointer_next;
  logic [PW-1:0] commit_pointer, commit_pointer_next;
  logic [PW-1:0] read_pointer, read_pointer_next;
  logic [PW-1:0] fill_next;
  write_state_t  write_state, write_state_next;

  logic ram_write, ram_read, overflow_next, underflow_next, dropped_next;
  logic ram_valid, ram_valid_next, valid_next, out_load, pop;
  logic [DATA_WIDTH:0] ram_q, out_word;

  generic_dual_port_ram #(
    .WIDTH         (DATA_WIDTH + 1),
    .ADDRESS_WIDTH (AW)
  ) u_ram (
    .write_clock   (clock),
    .write_enable  (ram_write),
    .write_address (write_pointer[AW-1:0]),
    .write_data    ({write_last, write_data}),
    .read_clock    (clock),
    .read_reset    (reset),
    .read_enable   (ram_read),
    .read_address  (read_pointer[AW-1:0]),
    .read_data     (ram_q)
  );

  always_comb begin
    write_pointer_next  = write_pointer;
    commit_pointer_next = commit_pointer;
    write_state_next    = write_state;
    ram_write           = 1'b0;
    overflow_next       = 1'b0;
    dropped_next        = 1'b0;
    if (PACKET_MODE == 0) begin
      if (write_enable) begin
        if (full) overflow_next = 1'b1;
        else begin
          ram_write          = 1'b1;
          write_pointer_next = write_pointer + ONE;
        end
      end
      commit_pointer_next = write_pointer_next;
    end else begin
      unique case (write_state)
        WRITE_IDLE, WRITE_PACKET: begin
          if (write_drop && (write_enable || write_state == WRITE_PACKET)) begin
            write_pointer_next = commit_pointer;
            dropped_next       = 1'b1;
            write_state_next   = WRITE_IDLE;
          end else if (write_enable && full) begin
            // A rejected word mid-packet rewinds; the tail is swallowed until its last word.
            overflow_next    = 1'b1;
            write_state_next = write_last ? WRITE_IDLE : WRITE_DISCARD;
            if (write_state == WRITE_PACKET) begin
              write_pointer_next = commit_pointer;
              dropped_next       = 1'b1;
            end
          end else if (write_enable) begin
            ram_write          = 1'b1;
            write_pointer_next = write_pointer + ONE;
            if (write_last) begin
              commit_pointer_next = write_pointer_next;
              write_state_next    = WRITE_IDLE;
            end else begin
              write_state_next = WRITE_PACKET;
            end
          end
        end
        WRITE_DISCARD: if (write_enable && write_last) write_state_next = WRITE_IDLE;
        default:       write_state_next = WRITE_IDLE;
      endcase
    end
  end

  always_comb begin
    pop            = 1'b0;
    out_load       = 1'b0;
    ram_read       = 1'b0;
    ram_valid_next = 1'b0;
    valid_next     = 1'b0;
    underflow_next = 1'b0;
    if (FIRST_WORD_FALL_THROUGH == 0) begin
      ram_read       = read_enable && !empty;
      underflow_next = read_enable && empty;
      valid_next     = ram_read;
    end else begin
      // Two-stage prefetch: RAM output register feeds the presented-word register.
      pop            = read_enable && read_data_valid;
      out_load       = ram_valid && (!read_data_valid || pop);
      ram_read       = !empty && (!ram_valid || out_load);
      ram_valid_next = ram_read || (ram_valid && !out_load);
      valid_next     = out_load || (read_data_valid && !pop);
      underflow_next = read_enable && !read_data_valid;
    end
    read_pointer_next = ram_read ? read_pointer + ONE : read_pointer;
    fill_next         = write_pointer_next - read_pointer_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_pointer   <= '0;
      commit_pointer  <= '0;
      read_pointer    <= '0;
      write_state     <= WRITE_IDLE;
      full            <= 1'b0;
      empty           <= 1'b1;
      almost_full     <= 1'b0;
      almost_empty    <= 1'b1;
      fill_count      <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      packet_dropped  <= 1'b0;
      read_data_valid <= 1'b0;
      ram_valid       <= 1'b0;
      out_word        <= '0;
    end else begin
      write_pointer   <= write_pointer_next;
      commit_pointer  <= commit_pointer_next;
      read_pointer    <= read_pointer_next;
      write_state     <= write_state_next;
      full            <= (write_pointer_next ^ read_pointer_next) == WRAP_ONLY;
      empty           <= commit_pointer_next == read_pointer_next;
      almost_full     <= fill_next >= FULL_MARK;
      almost_empty    <= fill_next <= EMPTY_MARK;
      fill_count      <= fill_next;
      overflow        <= overflow_next;
      underflow       <= underflow_next;
      packet_dropped  <= dropped_next;
      read_data_valid <= valid_next;
      ram_valid       <= ram_valid_next;
      if (out_load) out_word <= ram_q;
    end
  end

  assign read_data = (FIRST_WORD_FALL_THROUGH != 0) ? out_word[DATA_WIDTH-1:0] : ram_q[DATA_WIDTH-1:0];
  assign read_last = (FIRST_WORD_FALL_THROUGH != 0) ? out_word[DATA_WIDTH]     : ram_q[DATA_WIDTH];

endmodule

// File: tb/tb_generic_synchronous_packet_fifo.sv
// Directed bench: plain, fall-through and packet-mode FIFOs driven from one shared stimulus.
module tb_generic_synchronous_packet_fifo;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned PW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic write_enable = 1'b0, write_last = 1'b0, write_drop = 1'b0, read_enable = 1'b0;
  logic [W-1:0] write_data = '0;

  logic [W-1:0]  read_data [3];
  logic [PW-1:0] fill_count [3];
  logic read_last [3], read_data_valid [3], full [3], empty [3];
  logic almost_full [3], almost_empty [3], overflow [3], underflow [3], packet_dropped [3];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  generic_synchronous_packet_fifo #(.DATA_WIDTH(W), .DATA_DEPTH(D), .FIRST_WORD_FALL_THROUGH(0),
    .PACKET_MODE(0), .ALMOST_FULL_THRESHOLD(6), .ALMOST_EMPTY_THRESHOLD(2)) u_plain (
    .clock(clock), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .write_last(write_last), .write_drop(write_drop), .read_enable(read_enable),
    .read_data(read_data[0]), .read_last(read_last[0]), .read_data_valid(read_data_valid[0]),
    .full(full[0]), .empty(empty[0]), .almost_full(almost_full[0]), .almost_empty(almost_empty[0]),
    .fill_count(fill_count[0]), .overflow(overflow[0]), .underflow(underflow[0]),
    .packet_dropped(packet_dropped[0]));

  generic_synchronous_packet_fifo #(.DATA_WIDTH(W), .DATA_DEPTH(D), .FIRST_WORD_FALL_THROUGH(1),
    .PACKET_MODE(0), .ALMOST_FULL_THRESHOLD(6), .ALMOST_EMPTY_THRESHOLD(2)) u_fwft (
    .clock(clock), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .write_last(write_last), .write_drop(write_drop), .read_enable(read_enable),
    .read_data(read_data[1]), .read_last(read_last[1]), .read_data_valid(read_data_valid[1]),
    .full(full[1]), .empty(empty[1]), .almost_full(almost_full[1]), .almost_empty(almost_empty[1]),
    .fill_count(fill_count[1]), .overflow(overflow[1]), .underflow(underflow[1]),
    .packet_dropped(packet_dropped[1]));

  generic_synchronous_packet_fifo #(.DATA_WIDTH(W), .DATA_DEPTH(D), .FIRST_WORD_FALL_THROUGH(0),
    .PACKET_MODE(1), .ALMOST_FULL_THRESHOLD(6), .ALMOST_EMPTY_THRESHOLD(2)) u_packet (
    .clock(clock), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .write_last(write_last), .write_drop(write_drop), .read_enable(read_enable),
    .read_data(read_data[2]), .read_last(read_last[2]), .read_data_valid(read_data_valid[2]),
    .full(full[2]), .empty(empty[2]), .almost_full(almost_full[2]), .almost_empty(almost_empty[2]),
    .fill_count(fill_count[2]), .overflow(overflow[2]), .underflow(underflow[2]),
    .packet_dropped(packet_dropped[2]));

  typedef struct packed {
    logic [W-1:0]  data;
    logic          last;
    logic          valid;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic [PW-1:0] count;
    logic          ovf;
    logic          unf;
    logic          drop;
  } obs_t;

  typedef struct {
    logic         we;
    logic [W-1:0] wd;
    logic         re;
    obs_t         exp;
  } vector_t;

  vector_t vec [$];

  function automatic obs_t sample(input int unsigned i);
    obs_t o;
    o.data  = read_data[i];      o.last = read_last[i];     o.valid = read_data_valid[i];
    o.full  = full[i];           o.empty = empty[i];        o.af = almost_full[i];
    o.ae    = almost_empty[i];   o.count = fill_count[i];   o.ovf = overflow[i];
    o.unf   = underflow[i];      o.drop = packet_dropped[i];
    return o;
  endfunction

  function automatic obs_t mk(input logic [W-1:0] d, input logic l, v, f, e, af, ae,
                              input logic [PW-1:0] c, input logic o, u, p);
    obs_t r;
    r.data = d; r.last = l; r.valid = v; r.full = f; r.empty = e; r.af = af; r.ae = ae;
    r.count = c; r.ovf = o; r.unf = u; r.drop = p;
    return r;
  endfunction

  function automatic vector_t mkv(input logic we, input logic [W-1:0] wd, input logic re, input obs_t e);
    vector_t v;
    v.we = we; v.wd = wd; v.re = re; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [W-1:0] wd, input logic wl, input logic wdrop, input logic re);
    write_enable = we; write_data = wd; write_last = wl; write_drop = wdrop; read_enable = re;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    write_enable = 1'b0; write_last = 1'b0; write_drop = 1'b0; read_enable = 1'b0; write_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // Plain FIFO table: fill, overflow, drain, underflow.
    vec.push_back(mkv(0, 0, 0, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0)));
    for (int k = 1; k <= 8; k++)
      vec.push_back(mkv(1, W'(k), 0, mk(0, 0, 0, k == 8, 0, k >= 6, k <= 2, PW'(k), 0, 0, 0)));
    vec.push_back(mkv(1, 16'h0009, 0, mk(0, 0, 0, 1, 0, 1, 0, 8, 1, 0, 0)));
    for (int j = 1; j <= 8; j++)
      vec.push_back(mkv(0, 0, 1, mk(W'(j), 0, 1, 0, j == 8, (8 - j) >= 6, (8 - j) <= 2, PW'(8 - j), 0, 0, 0)));
    vec.push_back(mkv(0, 0, 1, mk(16'h0008, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0)));
    vec.push_back(mkv(0, 0, 0, mk(16'h0008, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0)));

    do_reset();
    reset = 1'b1;
    #2;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_state_%0d", i), 32'(sample(i)), 32'(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0)));
    do_reset();

    foreach (vec[i]) begin
      cyc(vec[i].we, vec[i].wd, 1'b0, 1'b0, vec[i].re);
      check($sformatf("plain_vec%0d", i), 32'(sample(0)), 32'(vec[i].exp));
    end

    // Fall-through: single word latency, pop, then underflow.
    do_reset();
    cyc(1, 16'hABCD, 0, 0, 0);
    check("fwft_valid_edge0", 32'(read_data_valid[1]), 0);
    cyc(0, 0, 0, 0, 0);
    check("fwft_valid_edge1", 32'(read_data_valid[1]), 0);
    cyc(0, 0, 0, 0, 0);
    check("fwft_word", {15'd0, read_data_valid[1], read_data[1]}, {15'd0, 1'b1, 16'hABCD});
    cyc(0, 0, 0, 0, 1);
    check("fwft_pop", {read_data_valid[1], underflow[1]}, 2'b00);
    cyc(0, 0, 0, 0, 1);
    check("fwft_underflow", {read_data_valid[1], underflow[1]}, 2'b01);

    // Fall-through streaming: one word per cycle once the pipeline is primed.
    do_reset();
    for (int k = 0; k < 22; k++) begin
      cyc(k < 20, W'(16'h0100 + k), 0, 0, 1);
      if (k >= 2)
        check($sformatf("fwft_stream%0d", k), {15'd0, read_data_valid[1], read_data[1]},
              {15'd0, 1'b1, W'(16'h0100 + k - 2)});
    end
    cyc(0, 0, 0, 0, 1);
    check("fwft_stream_drained", 32'(read_data_valid[1]), 0);

    // Packet mode: commit on last word, last flag stored per word.
    do_reset();
    cyc(1, 16'h00A1, 0, 0, 0);
    check("pkt_uncommitted1", {empty[2], fill_count[2]}, {1'b1, 4'd1});
    cyc(1, 16'h00A2, 0, 0, 0);
    check("pkt_uncommitted2", {empty[2], fill_count[2]}, {1'b1, 4'd2});
    cyc(1, 16'h00A3, 1, 0, 0);
    check("pkt_committed", {empty[2], fill_count[2]}, {1'b0, 4'd3});
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      check($sformatf("pkt_read%0d", i), {read_data_valid[2], read_last[2], read_data[2]},
            {1'b1, i == 2, W'(16'h00A1 + i)});
    end
    check("pkt_empty_after", 32'(empty[2]), 1);

    // Packet mode: explicit drop, then an intact packet.
    cyc(1, 16'h00B1, 0, 0, 0);
    cyc(1, 16'h00B2, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("drop_pulse", {packet_dropped[2], empty[2], fill_count[2]}, {1'b1, 1'b1, 4'd0});
    cyc(0, 0, 0, 0, 0);
    check("drop_pulse_end", 32'(packet_dropped[2]), 0);
    cyc(1, 16'h00C1, 0, 0, 0);
    cyc(1, 16'h00C2, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 1);
      check($sformatf("after_drop_read%0d", i), {read_data_valid[2], read_last[2], read_data[2]},
            {1'b1, i == 1, W'(16'h00C1 + i)});
    end

    // Packet mode: oversize packet behind three committed words.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, W'(16'h00D1 + i), i == 2, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, W'(16'h00E0 + i), 0, 0, 0);
    check("oversize_full", {full[2], fill_count[2]}, {1'b1, 4'd8});
    cyc(1, 16'h00E5, 0, 0, 0);
    check("oversize_rewind", {packet_dropped[2], full[2], fill_count[2]}, {1'b1, 1'b0, 4'd3});
    for (int i = 6; i < 10; i++) cyc(1, W'(16'h00E0 + i), i == 9, 0, 0);
    check("oversize_swallow", {packet_dropped[2], overflow[2], empty[2], fill_count[2]},
          {1'b0, 1'b0, 1'b0, 4'd3});
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      check($sformatf("oversize_read%0d", i), {read_data_valid[2], read_last[2], read_data[2]},
            {1'b1, i == 2, W'(16'h00D1 + i)});
    end
    cyc(1, 16'h00F1, 0, 0, 0);
    cyc(1, 16'h00F2, 1, 0, 0);
    check("next_packet_count", {empty[2], fill_count[2]}, {1'b0, 4'd2});
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 1);
      check($sformatf("next_packet_read%0d", i), {read_data_valid[2], read_last[2], read_data[2]},
            {1'b1, i == 1, W'(16'h00F1 + i)});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
